cook_ctrl: RTL and testbench

COOK_CTRL -- requirements
Module: cook_ctrl

---
 rtl/cook_ctrl.sv | 149 ++++++++++++++
 tb/tb_cook_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cook_ctrl.sv
// Microwave cook controller: keypad time entry, load/countdown of external BCD
// digit counters, pause/resume on door or stop, and a cook-complete indicator.
module cook_ctrl (
  input  logic        clk,
  input  logic        clrn,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        stop_clr,
  input  logic        door_open,
  input  logic        tick,
  input  logic [3:0]  zero,
  output logic [15:0] data,
  output logic        loadn,
  output logic [3:0]  en,
  output logic        mag_on,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_COOK  = 3'd2,
    S_PAUSE = 3'd3,
    S_CLEAR = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] data_q, data_d;
  logic        loadn_q, loadn_d;
  logic [3:0]  en_q, en_d;
  logic        mag_on_q, mag_on_d;
  logic        done_q, done_d;

  // Cascade enables: a digit steps only when every lower digit is about to wrap.
  function automatic logic [3:0] tick_en(input logic [3:0] z);
    return {&z[2:0], &z[1:0], z[0], 1'b1};
  endfunction

  // An empty entry is accepted (becomes quick start); seconds tens above 5 is not a valid time.
  function automatic logic start_ok(input logic [15:0] d);
    return (d == 16'h0000) || (d[7:4] <= 4'd5);
  endfunction

  // State and registered outputs.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q  <= S_IDLE;
      data_q   <= 16'h0000;
      loadn_q  <= 1'b1;
      en_q     <= 4'b0000;
      mag_on_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      loadn_q  <= loadn_d;
      en_q     <= en_d;
      mag_on_q <= mag_on_d;
      done_q   <= done_d;
    end
  end

  // Next state plus the output values that belong to that next state.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    loadn_d  = 1'b1;
    en_d     = 4'b0000;
    mag_on_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (stop_clr) begin
          data_d = 16'h0000;
        end else if (start) begin
          if (!door_open && start_ok(data_q)) begin
            state_d = S_LOAD;
            loadn_d = 1'b0;
            en_d    = 4'b1111;
            data_d  = (data_q == 16'h0000) ? 16'h0030 : data_q;
          end else begin
            state_d = S_IDLE;
          end
        end else if (key_valid && (key_digit <= 4'd9)) begin
          data_d = {data_q[11:0], key_digit};
        end else begin
          data_d = data_q;
        end
      end
      S_LOAD: begin
        state_d  = S_COOK;
        mag_on_d = 1'b1;
      end
      S_COOK: begin
        // Door/stop win over expiry and discard any coincident tick.
        if (door_open || stop_clr) begin
          state_d = S_PAUSE;
        end else if (&zero) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          mag_on_d = 1'b1;
          if (tick) begin
            en_d = tick_en(zero);
          end else begin
            en_d = 4'b0000;
          end
        end
      end
      S_PAUSE: begin
        if (stop_clr) begin
          state_d = S_CLEAR;
          data_d  = 16'h0000;
          loadn_d = 1'b0;
          en_d    = 4'b1111;
        end else if (start && !door_open) begin
          state_d  = S_COOK;
          mag_on_d = 1'b1;
        end else begin
          state_d = S_PAUSE;
        end
      end
      S_CLEAR: begin
        state_d = S_IDLE;
      end
      S_DONE: begin
        if (door_open || stop_clr || start) begin
          state_d = S_IDLE;
          data_d  = 16'h0000;
        end else begin
          done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        data_d  = 16'h0000;
      end
    endcase
  end

  assign data   = data_q;
  assign loadn  = loadn_q;
  assign en     = en_q;
  assign mag_on = mag_on_q;
  assign done   = done_q;

endmodule

// File: tb/tb_cook_ctrl.sv
// Bench for cook_ctrl: attaches mod-10/mod-6 BCD down counters and compares
// every cycle against a seconds-based behavioural model of the oven.
module tb_cook_ctrl;

  logic        clk = 1'b0;
  logic        clrn, key_valid, start, stop_clr, door_open, tick;
  logic [3:0]  key_digit, zero, en;
  logic [15:0] data, cnt;
  logic        loadn, mag_on, done;

  always #5 clk = ~clk;

  cook_ctrl dut (
    .clk(clk), .clrn(clrn), .key_valid(key_valid), .key_digit(key_digit),
    .start(start), .stop_clr(stop_clr), .door_open(door_open), .tick(tick),
    .zero(zero), .data(data), .loadn(loadn), .en(en), .mag_on(mag_on), .done(done)
  );

  // Attached digit counters {min tens, min ones, sec tens (mod 6), sec ones}.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) cnt <= 16'h0000;
    else if (!loadn) cnt <= data;
    else begin
      if (en[0]) cnt[3:0]   <= (cnt[3:0]   == 4'd0) ? 4'd9 : cnt[3:0]   - 4'd1;
      if (en[1]) cnt[7:4]   <= (cnt[7:4]   == 4'd0) ? 4'd5 : cnt[7:4]   - 4'd1;
      if (en[2]) cnt[11:8]  <= (cnt[11:8]  == 4'd0) ? 4'd9 : cnt[11:8]  - 4'd1;
      if (en[3]) cnt[15:12] <= (cnt[15:12] == 4'd0) ? 4'd9 : cnt[15:12] - 4'd1;
    end
  end
  assign zero = {cnt[15:12] == 4'd0, cnt[11:8] == 4'd0, cnt[7:4] == 4'd0, cnt[3:0] == 4'd0};

  localparam int M_IDLE = 0, M_LOAD = 1, M_COOK = 2, M_PAUSE = 3, M_CLEAR = 4, M_DONE = 5;
  int          md, m_secs;
  logic [15:0] m_data;
  logic        m_loadn, m_mag, m_done;
  logic [3:0]  m_en;
  int          total = 0, bad = 0;
  logic        last_tk = 1'b0;

  function automatic int bcd2s(input logic [15:0] d);
    return int'(d[15:12]) * 600 + int'(d[11:8]) * 60 + int'(d[7:4]) * 10 + int'(d[3:0]);
  endfunction

  // Which digits must step to take s seconds down by one.
  function automatic logic [3:0] en_for(input int s);
    logic [3:0] r;
    r[0] = 1'b1;
    r[1] = (s % 10) == 0;
    r[2] = (s % 60) == 0;
    r[3] = (s % 600) == 0;
    return r;
  endfunction

  task automatic model_reset();
    md = M_IDLE; m_data = 16'h0000; m_secs = 0;
    m_loadn = 1'b1; m_en = 4'b0000; m_mag = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_step(input logic kv, input logic [3:0] kd, input logic st,
                            input logic sc, input logic dr, input logic tk);
    int nsecs, nmd;
    logic [15:0] ndata;
    logic [3:0] nen;
    logic nloadn, nmag, ndone;
    nsecs = m_secs;
    if (!m_loadn) nsecs = bcd2s(m_data);
    else if (m_en != 4'b0000) nsecs = m_secs - 1;
    nmd = md; ndata = m_data; nen = 4'b0000; nloadn = 1'b1; nmag = 1'b0; ndone = 1'b0;
    case (md)
      M_IDLE:
        if (sc) ndata = 16'h0000;
        else if (st) begin
          if (!dr && (m_data == 16'h0000 || m_data[7:4] <= 4'd5)) begin
            nmd = M_LOAD; nloadn = 1'b0; nen = 4'b1111;
            if (m_data == 16'h0000) ndata = 16'h0030;
          end
        end else if (kv && kd <= 4'd9) ndata = {m_data[11:0], kd};
      M_LOAD: begin nmd = M_COOK; nmag = 1'b1; end
      M_COOK:
        if (dr || sc) nmd = M_PAUSE;
        else if (m_secs == 0) begin nmd = M_DONE; ndone = 1'b1; end
        else begin nmag = 1'b1; if (tk) nen = en_for(m_secs); end
      M_PAUSE:
        if (sc) begin nmd = M_CLEAR; ndata = 16'h0000; nloadn = 1'b0; nen = 4'b1111; end
        else if (st && !dr) begin nmd = M_COOK; nmag = 1'b1; end
      M_CLEAR: nmd = M_IDLE;
      default:
        if (dr || sc || st) begin nmd = M_IDLE; ndata = 16'h0000; end
        else ndone = 1'b1;
    endcase
    md = nmd; m_data = ndata; m_secs = nsecs; m_en = nen;
    m_loadn = nloadn; m_mag = nmag; m_done = ndone;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("data", {16'h0000, data}, {16'h0000, m_data});
    chk("loadn", {31'd0, loadn}, {31'd0, m_loadn});
    chk("en", {28'd0, en}, {28'd0, m_en});
    chk("mag_on", {31'd0, mag_on}, {31'd0, m_mag});
    chk("done", {31'd0, done}, {31'd0, m_done});
    chk("counter_secs", bcd2s(cnt), m_secs);
  endtask

  task automatic cyc(input logic kv, input logic [3:0] kd, input logic st,
                     input logic sc, input logic tk);
    key_valid = kv; key_digit = kd; start = st; stop_clr = sc; tick = tk;
    @(posedge clk);
    model_step(kv, kd, st, sc, door_open, tk);
    last_tk = tk;
    @(negedge clk);
    check_all();
  endtask

  task automatic key(input logic [3:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  // One tick followed by two quiet cycles, until done rises or the budget runs out.
  task automatic run_to_done(input int max_ticks, output int n);
    n = 0;
    while (n < max_ticks && done !== 1'b1) begin
      cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      n++;
    end
  endtask

  initial begin
    int n;
    logic kv, st, sc, tk;
    logic [3:0] kd;
    clrn = 1'b0; key_valid = 1'b0; key_digit = 4'd0; start = 1'b0;
    stop_clr = 1'b0; door_open = 1'b0; tick = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    clrn = 1'b1;

    // Entry shifting and rejection of non-BCD keys.
    key(4'd1); key(4'd2); key(4'd3); key(4'd4); key(4'd5);
    chk("entry_2345", {16'h0000, data}, 32'h0000_2345);
    key(4'd11);
    chk("entry_badkey", {16'h0000, data}, 32'h0000_2345);
    key(4'd0); key(4'd1); key(4'd0); key(4'd0);
    chk("entry_0100", {16'h0000, data}, 32'h0000_0100);

    // One minute cook.
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("load_loadn", {31'd0, loadn}, 32'd0);
    chk("load_en", {28'd0, en}, 32'hF);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("cook_mag", {31'd0, mag_on}, 32'd1);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    chk("first_tick_en", {28'd0, en}, 32'h7);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("first_tick_cnt", {16'h0000, cnt}, 32'h0000_0059);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    run_to_done(100, n);
    chk("ticks_60", n + 1, 60);
    chk("done_60", {31'd0, done}, 32'd1);
    chk("mag_off_60", {31'd0, mag_on}, 32'd0);

    // Clear from DONE, then quick start.
    cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    chk("done_clear_data", {16'h0000, data}, 32'd0);
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("quick_data", {16'h0000, data}, 32'h0000_0030);
    chk("quick_loadn", {31'd0, loadn}, 32'd0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    run_to_done(60, n);
    chk("ticks_30", n, 30);

    // Pause/resume/clear at 0042.
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    key(4'd4); key(4'd2);
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    door_open = 1'b1;
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    chk("pause_mag", {31'd0, mag_on}, 32'd0);
    chk("pause_en", {28'd0, en}, 32'd0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("pause_hold", {16'h0000, cnt}, 32'h0000_0042);
    door_open = 1'b0;
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("resume_mag", {31'd0, mag_on}, 32'd1);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("resume_cnt", {16'h0000, cnt}, 32'h0000_0041);
    cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    chk("clear_loadn", {31'd0, loadn}, 32'd0);
    chk("clear_en", {28'd0, en}, 32'hF);
    chk("clear_data", {16'h0000, data}, 32'd0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("clear_cnt", {16'h0000, cnt}, 32'd0);

    // Invalid seconds tens; then start+stop together while paused.
    key(4'd7); key(4'd0);
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("bad_start_loadn", {31'd0, loadn}, 32'd1);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("bad_start_mag", {31'd0, mag_on}, 32'd0);
    chk("bad_start_data", {16'h0000, data}, 32'h0000_0070);
    key(4'd0); key(4'd0); key(4'd1); key(4'd0);
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    chk("start_stop_clear", {31'd0, loadn}, 32'd0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of cooking.
    key(4'd2); key(4'd0);
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    chk("pre_reset_mag", {31'd0, mag_on}, 32'd1);
    #2 clrn = 1'b0;
    #1 model_reset();
    check_all();
    @(negedge clk);
    clrn = 1'b1;
    cyc(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("post_reset_quick", {16'h0000, data}, 32'h0000_0030);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      kv = ($urandom_range(0, 4) == 0);
      kd = 4'($urandom_range(0, 15));
      st = ($urandom_range(0, 19) == 0);
      sc = ($urandom_range(0, 39) == 0);
      tk = !last_tk && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 49) == 0) door_open = ~door_open;
      cyc(kv, kd, st, sc, tk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
